prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run controller for the instruction-fetch program counter. It sequences a series of programs stored at fixed base addresses in instruction memory: it holds fetch while `Start` is asserted and launches the next program with a one-cycle absolute jump to that program's base. It then arbitrates the fetch unit's branch inputs between itself and the core's branch logic, detects program completion via `Halt`, and reports a per-program cycle count. It sits between the top-level testbench/host handshake and the fetch unit's `Start`/`BranchEn`/`Target` inputs.

## Interface
- `NUM_PROGS`, 3: number of programs in the series; index wraps after the last.
- `PC_W`, 10: program counter / target width.
- `CNT_W`, 16: cycle counter width.
- `PROG_BASE`, {0, 256, 512}: per-program base address, `NUM_PROGS` entries of `PC_W` bits.

- `Clk` in 1: single clock; all state changes on posedge.
- `Reset` in 1: synchronous, active-high; forces all state to reset values.
- `Start` in 1: host request; level-held; launch occurs on release.
- `Halt` in 1: core's halt/done decode, valid only in RUN.
- `CoreBranchEn` in 1: core's taken-branch request.
- `CoreTarget` in PC_W: core's branch target.
- `FetchHold` out 1: drives the fetch unit's `Start` (hold PC).
- `BranchEnOut` out 1: drives the fetch unit's `BranchEn`.
- `TargetOut` out PC_W: drives the fetch unit's `Target`.
- `ProgIdx` out $clog2(NUM_PROGS): index of current/last program.
- `Done` out 1: program finished; held until next `Start`.
- `CycleCount` out CNT_W: cycles spent in current/last program.
- `CountSat` out 1: `CycleCount` saturated at all-ones.

## Operation
- States: IDLE, ARM, LAUNCH, RUN, DONE (registered).
- IDLE: `Start`=1 -> ARM; `ProgIdx` keeps its value (0 after reset).
- ARM: `Start`=1 -> stay; `Start`=0 -> LAUNCH.
- LAUNCH: unconditional -> RUN. `CycleCount` and `CountSat` clear at entry.
- RUN: `Halt`=1 -> DONE; otherwise stay. `CycleCount` increments every RUN cycle, including the `Halt` cycle, and saturates at 2^CNT_W-1 with `CountSat`=1.
- DONE: `Start`=1 -> ARM, `ProgIdx` <= `ProgIdx`+1, wrapping from NUM_PROGS-1 to 0, and `Done` clears.
- Outputs:
  - `FetchHold` = 1 in IDLE, ARM, DONE.
  - `BranchEnOut`/`TargetOut`:
    - LAUNCH: 1 / `PROG_BASE[ProgIdx]`.
    - RUN: `CoreBranchEn & ~Halt` / `CoreTarget`.
    - Otherwise: 0 / 0.
  - `Done` = 1 in DONE only.
- Arbitration: the sequencer's own jump (LAUNCH) and the core branch can never overlap. `Halt` suppresses a same-cycle core branch.
- Ignored inputs: `Start` in RUN/LAUNCH; `Halt` outside RUN; `CoreBranchEn` outside RUN.

## Timing
- Reset values: state IDLE, `ProgIdx` 0, `CycleCount` 0, `CountSat` 0, `Done` 0, `FetchHold` 1, `BranchEnOut` 0, `TargetOut` 0.
- Launch handshake:
  - `Start` sampled 1 at edge k -> ARM.
  - First edge m sampling `Start`=0 -> LAUNCH during cycle m..m+1.
  - Fetch loads `PROG_BASE` at edge m+1; first program instruction presented in cycle m+1..m+2.
- Launch latency: 1 cycle from `Start` release.
- Completion: `Halt` sampled at edge h -> `Done`=1 and `FetchHold`=1 from h; `CycleCount` is final from h.
- `BranchEnOut`/`TargetOut` in RUN are combinational from core inputs (zero latency); all other outputs are register-derived.
- Single-cycle `Start` pulse: ARM for one cycle, then LAUNCH.
- Reset mid-RUN: next cycle IDLE, `ProgIdx` 0, counters cleared, fetch held.

## Structure
- Package `prog_seq_pkg`: state enum `seq_state_t`, default `PROG_BASE` constant, `PC_W`/`CNT_W` defaults.
- Sub-module `sat_counter` (CNT_W, synchronous clear, enable, saturate flag) for `CycleCount`/`CountSat`.
- Next-state logic, output decode and branch mux stay in `prog_sequencer`.

## Test plan
- Reset, then `Start` high 3 cycles then low -> `FetchHold` 1 through ARM, one-cycle `BranchEnOut`=1 with `TargetOut`=0, `FetchHold`=0 thereafter.
- Run 20 cycles then `Halt` -> `Done`=1, `CycleCount`=21, `FetchHold`=1; next `Start` -> `ProgIdx`=1, launch `TargetOut`=256.
- Three full programs then a fourth `Start` -> `ProgIdx` wraps 2 -> 0, `TargetOut`=0.
- In RUN, `CoreBranchEn`=1 with `CoreTarget`=0x3A -> passthrough same cycle; same with `Halt`=1 -> `BranchEnOut`=0.
- `CNT_W`=4, run 20 cycles -> `CycleCount`=15, `CountSat`=1.
- `Reset` asserted mid-RUN -> IDLE next cycle, `ProgIdx`=0, `CycleCount`=0, `Done`=0; `Start`/`Halt` in wrong states have no effect.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg
//   Shared types and default parameters for the program-series run
//   controller: the FSM state type, default PC/counter widths and the
//   default table of program base addresses.
package prog_seq_pkg;

    localparam int NUM_PROGS_DEF = 3;
    localparam int PC_W_DEF      = 10;
    localparam int CNT_W_DEF     = 16;

    // Entry [i] is the base address of program i (entry 0 is rightmost).
    localparam logic [NUM_PROGS_DEF-1:0][PC_W_DEF-1:0] PROG_BASE_DEF =
        {10'd512, 10'd256, 10'd0};

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ARM    = 3'd1,
        SEQ_LAUNCH = 3'd2,
        SEQ_RUN    = 3'd3,
        SEQ_DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk_i    clock
//     rst_i    synchronous active-high reset (clears count)
//     clr_i    synchronous clear (clears count)
//     en_i     count enable
//     count_o  current count
//     sat_o    count has reached all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;
    // Saturation is simply "all ones", so no separate flag register is needed.
    assign sat_o   = &cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Run controller for the instruction-fetch PC. Holds fetch while the host
//   asserts Start, launches the next program with a one-cycle absolute jump
//   to its base address on Start release, then passes the core's branches
//   through until Halt, counting cycles spent running.
//   Ports:
//     Clk, Reset         clock, synchronous active-high reset
//     Start              host request (level; launch on release)
//     Halt               core done decode (used in RUN only)
//     CoreBranchEn/CoreTarget  core taken-branch request and target
//     FetchHold          fetch unit Start (hold PC)
//     BranchEnOut/TargetOut    fetch unit BranchEn/Target
//     ProgIdx            index of current/last program
//     Done               program finished, held until next Start
//     CycleCount/CountSat      run-cycle count and its saturation flag
//
//   state  | meaning
//   IDLE   | after reset, fetch held, waiting for Start
//   ARM    | Start held high, fetch held
//   LAUNCH | one-cycle jump to PROG_BASE[ProgIdx]
//   RUN    | program executing, core branches passed through
//   DONE   | Halt seen, fetch held, waiting for next Start
module prog_sequencer import prog_seq_pkg::*; #(
    parameter int NUM_PROGS = NUM_PROGS_DEF,
    parameter int PC_W      = PC_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter logic [NUM_PROGS-1:0][PC_W-1:0] PROG_BASE = PROG_BASE_DEF
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Halt,
    input  logic                         CoreBranchEn,
    input  logic [PC_W-1:0]              CoreTarget,
    output logic                         FetchHold,
    output logic                         BranchEnOut,
    output logic [PC_W-1:0]              TargetOut,
    output logic [$clog2(NUM_PROGS)-1:0] ProgIdx,
    output logic                         Done,
    output logic [CNT_W-1:0]             CycleCount,
    output logic                         CountSat
);

    localparam int IDX_W = $clog2(NUM_PROGS);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cnt_clr;
    logic             cnt_en;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SEQ_IDLE:   if (Start) state_d = SEQ_ARM;
            SEQ_ARM:    if (!Start) state_d = SEQ_LAUNCH;
            SEQ_LAUNCH: state_d = SEQ_RUN;
            SEQ_RUN:    if (Halt) state_d = SEQ_DONE;
            SEQ_DONE: begin
                if (Start) begin
                    state_d = SEQ_ARM;
                    idx_d   = (idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
            default:    state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SEQ_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Clear on the edge that enters LAUNCH so the count covers RUN cycles only.
    assign cnt_clr = (state_q == SEQ_ARM) && !Start;
    assign cnt_en  = (state_q == SEQ_RUN);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (CycleCount),
        .sat_o   (CountSat)
    );

    // LAUNCH and RUN are exclusive states, so the sequencer jump and the core
    // branch can never collide; Halt masks a same-cycle core branch.
    always_comb begin
        BranchEnOut = 1'b0;
        TargetOut   = '0;
        case (state_q)
            SEQ_LAUNCH: begin
                BranchEnOut = 1'b1;
                TargetOut   = PROG_BASE[idx_q];
            end
            SEQ_RUN: begin
                BranchEnOut = CoreBranchEn & ~Halt;
                TargetOut   = CoreTarget;
            end
            default: ;
        endcase
    end

    assign FetchHold = (state_q == SEQ_IDLE) || (state_q == SEQ_ARM) || (state_q == SEQ_DONE);
    assign Done      = (state_q == SEQ_DONE);
    assign ProgIdx   = idx_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Halt = 1'b0;
    logic        CoreBranchEn = 1'b0;
    logic [9:0]  CoreTarget = '0;

    logic        FetchHold, BranchEnOut, Done, CountSat;
    logic [9:0]  TargetOut;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCount;

    logic        f4_hold, f4_ben, f4_done, f4_sat;
    logic [9:0]  f4_tgt;
    logic [1:0]  f4_idx;
    logic [3:0]  f4_cnt;

    prog_sequencer u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .CoreBranchEn(CoreBranchEn), .CoreTarget(CoreTarget),
        .FetchHold(FetchHold), .BranchEnOut(BranchEnOut), .TargetOut(TargetOut),
        .ProgIdx(ProgIdx), .Done(Done), .CycleCount(CycleCount), .CountSat(CountSat)
    );

    prog_sequencer #(.CNT_W(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .CoreBranchEn(CoreBranchEn), .CoreTarget(CoreTarget),
        .FetchHold(f4_hold), .BranchEnOut(f4_ben), .TargetOut(f4_tgt),
        .ProgIdx(f4_idx), .Done(f4_done), .CycleCount(f4_cnt), .CountSat(f4_sat)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]  tq[$];
    logic [15:0] cq[$];
    logic [3:0]  c4q[$];
    logic        s4q[$];
    int          model_idx = 0;
    bit          model_done = 0;

    function automatic logic [9:0] base_of(input int i);
        case (i)
            0: return 10'd0;
            1: return 10'd256;
            default: return 10'd512;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 0; Halt = 0; CoreBranchEn = 0;
        tick(); tick();
        vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL reset_hold: got %b want 1", FetchHold); end
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL reset_ben: got %b want 0", BranchEnOut); end
        vectors++; if (TargetOut !== 10'd0) begin miscompares++; $display("FAIL reset_tgt: got %0d want 0", TargetOut); end
        vectors++; if (ProgIdx !== 2'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", ProgIdx); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", Done); end
        vectors++; if (CycleCount !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", CycleCount); end
        vectors++; if (CountSat !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", CountSat); end
        Reset = 1'b0;
        model_idx = 0;
        model_done = 0;
    endtask

    task automatic test_wrong_state();
        // Halt and core branch in IDLE must be ignored.
        Halt = 1'b1; CoreBranchEn = 1'b1; CoreTarget = 10'h155;
        tick();
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL idle_ben: got %b want 0", BranchEnOut); end
        tick();
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL idle_halt_done: got %b want 0", Done); end
        vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL idle_halt_hold: got %b want 1", FetchHold); end
        vectors++; if (CycleCount !== 16'd0) begin miscompares++; $display("FAIL idle_cnt: got %0d want 0", CycleCount); end
        Halt = 1'b0; CoreBranchEn = 1'b0; CoreTarget = '0;
    endtask

    task automatic do_launch(input int hold_cycles);
        int  lat;
        bit  found;
        logic [9:0] exp_t;
        if (model_done) model_idx = (model_idx + 1) % 3;
        model_done = 0;
        tq.push_back(base_of(model_idx));
        Start = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL arm_hold: got %b want 1", FetchHold); end
            vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL arm_ben: got %b want 0", BranchEnOut); end
        end
        Start = 1'b0;
        lat = 0; found = 0;
        while (!found && lat < 4) begin
            tick();
            lat++;
            if (BranchEnOut === 1'b1) found = 1;
        end
        exp_t = tq.pop_front();
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL launch_timeout: got no jump want jump to %0d", exp_t);
        end else begin
            if (TargetOut !== exp_t) begin miscompares++; $display("FAIL launch_tgt: got %0d want %0d", TargetOut, exp_t); end
            vectors++; if (lat != 1) begin miscompares++; $display("FAIL launch_lat: got %0d want 1", lat); end
            vectors++; if (FetchHold !== 1'b0) begin miscompares++; $display("FAIL launch_hold: got %b want 0", FetchHold); end
            vectors++; if (ProgIdx !== 2'(model_idx)) begin miscompares++; $display("FAIL launch_idx: got %0d want %0d", ProgIdx, model_idx); end
            vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL launch_done: got %b want 0", Done); end
        end
    endtask

    task automatic check_done();
        int  w;
        logic [15:0] ec;
        logic [3:0]  ec4;
        logic        es4;
        w = 0;
        while (Done !== 1'b1 && w < 4) begin tick(); w++; end
        ec = cq.pop_front(); ec4 = c4q.pop_front(); es4 = s4q.pop_front();
        vectors++;
        if (Done !== 1'b1) begin
            miscompares++; $display("FAIL done_timeout: got Done=%b want 1", Done);
        end else begin
            if (w != 0) begin miscompares++; $display("FAIL done_lat: got %0d want 0", w); end
            vectors++; if (CycleCount !== ec) begin miscompares++; $display("FAIL done_cnt: got %0d want %0d", CycleCount, ec); end
            vectors++; if (f4_cnt !== ec4) begin miscompares++; $display("FAIL done_cnt4: got %0d want %0d", f4_cnt, ec4); end
            vectors++; if (f4_sat !== es4) begin miscompares++; $display("FAIL done_sat4: got %b want %b", f4_sat, es4); end
            vectors++; if (CountSat !== 1'b0) begin miscompares++; $display("FAIL done_sat: got %b want 0", CountSat); end
            vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL done_hold: got %b want 1", FetchHold); end
        end
        tick();
        vectors++; if (Done !== 1'b1) begin miscompares++; $display("FAIL done_held: got %b want 1", Done); end
        vectors++; if (CycleCount !== ec) begin miscompares++; $display("FAIL done_cnt_held: got %0d want %0d", CycleCount, ec); end
        model_done = 1;
    endtask

    task automatic push_count(input int n);
        cq.push_back(16'(n));
        c4q.push_back((n >= 15) ? 4'd15 : 4'(n));
        s4q.push_back(n >= 15);
    endtask

    task automatic run_prog(input int n, input bit hold_start);
        tick();
        vectors++; if (FetchHold !== 1'b0) begin miscompares++; $display("FAIL run_hold: got %b want 0", FetchHold); end
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL run_ben: got %b want 0", BranchEnOut); end
        if (hold_start) Start = 1'b1;
        repeat (n) tick();
        Start = 1'b0;
        vectors++; if (CycleCount !== 16'(n)) begin miscompares++; $display("FAIL run_cnt: got %0d want %0d", CycleCount, n); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL run_done: got %b want 0", Done); end
        Halt = 1'b1;
        push_count(n + 1);
        tick();
        Halt = 1'b0;
        check_done();
    endtask

    task automatic test_branch();
        tick();
        CoreBranchEn = 1'b1; CoreTarget = 10'h03A;
        #1;
        vectors++; if (BranchEnOut !== 1'b1) begin miscompares++; $display("FAIL br_pass_en: got %b want 1", BranchEnOut); end
        vectors++; if (TargetOut !== 10'h03A) begin miscompares++; $display("FAIL br_pass_tgt: got %0h want 3a", TargetOut); end
        Halt = 1'b1;
        #1;
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL br_halt_mask: got %b want 0", BranchEnOut); end
        push_count(1);
        tick();
        Halt = 1'b0;
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL br_done_ben: got %b want 0", BranchEnOut); end
        vectors++; if (TargetOut !== 10'd0) begin miscompares++; $display("FAIL br_done_tgt: got %0d want 0", TargetOut); end
        check_done();
        CoreBranchEn = 1'b0; CoreTarget = '0;
    endtask

    task automatic test_reset_mid_run();
        tick();
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL rst_run_hold: got %b want 1", FetchHold); end
        vectors++; if (ProgIdx !== 2'd0) begin miscompares++; $display("FAIL rst_run_idx: got %0d want 0", ProgIdx); end
        vectors++; if (CycleCount !== 16'd0) begin miscompares++; $display("FAIL rst_run_cnt: got %0d want 0", CycleCount); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL rst_run_done: got %b want 0", Done); end
        vectors++; if (BranchEnOut !== 1'b0) begin miscompares++; $display("FAIL rst_run_ben: got %b want 0", BranchEnOut); end
        model_idx = 0;
        model_done = 0;
        tick();
        vectors++; if (FetchHold !== 1'b1) begin miscompares++; $display("FAIL rst_idle_hold: got %b want 1", FetchHold); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wrong_state();
        do_launch(3);  run_prog(20, 1'b0);
        do_launch(1);  run_prog(5, 1'b1);
        do_launch(2);  test_reset_mid_run();
        do_launch(1);  run_prog(3, 1'b0);
        do_launch(1);  run_prog(0, 1'b0);
        do_launch(1);  test_branch();
        do_launch(2);  run_prog(14, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
